// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared defaults and helpers for the round-robin counter scheduler.
//   NchDef, WidthDef, InitvalDef, DefdeltaDef - default parameter values
//   rr_next()                                 - next priority pointer after a grant
package cnt_sched_pkg;

    localparam int unsigned NchDef      = 4;
    localparam int unsigned WidthDef    = 4;
    localparam int unsigned InitvalDef  = 0;
    localparam int unsigned DefdeltaDef = 10;

    // Pointer moves to the slot just past the winner; with no winner it holds.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned g,
                                            input logic        vld,
                                            input int unsigned nch);
        if (vld) begin
            return (g + 1) % nch;
        end
        return ptr;
    endfunction

endpackage

// File: rtl/cnt_rr_arb.sv
// cnt_rr_arb: combinational round-robin arbiter.
//   req_i  - per-channel request
//   ptr_i  - index with highest priority this cycle
//   gnt_o  - one-hot grant (zero when no request)
//   idx_o  - encoded index of the granted channel
//   vld_o  - a grant was issued
module cnt_rr_arb
    import cnt_sched_pkg::*;
#(
    parameter int unsigned NCH  = NchDef,
    parameter int unsigned PtrW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NCH-1:0]  gnt_o,
    output logic [PtrW-1:0] idx_o,
    output logic            vld_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        // Walk ptr, ptr+1, ... wrapping; first set request wins.
        for (int unsigned i = 0; i < NCH; i++) begin
            int unsigned cand;
            cand = (32'(ptr_i) + i) % NCH;
            if (!vld_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = PtrW'(cand);
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler sharing one adder across a bank of counters.
//   clock_i    - clock, rising edge
//   reset_i    - synchronous active-high reset
//   req_i      - per-channel level request
//   use_def_i  - per-channel: add DEFDELTA instead of the delta field
//   delta_i    - packed per-channel increments, channel i at [i*WIDTH +: WIDTH]
//   clr_i      - per-channel synchronous reload to INITVAL
//   gnt_o      - combinational one-hot grant
//   cnt_o      - registered packed counter bank
//   wrap_o     - registered one-cycle carry-out pulse for the updated channel
//   busy_o     - any request pending
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int unsigned NCH      = NchDef,
    parameter int unsigned WIDTH    = WidthDef,
    parameter int unsigned INITVAL  = InitvalDef,
    parameter int unsigned DEFDELTA = DefdeltaDef
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NCH-1:0]     req_i,
    input  logic [NCH-1:0]     use_def_i,
    input  logic [NCH*WIDTH-1:0] delta_i,
    input  logic [NCH-1:0]     clr_i,
    output logic [NCH-1:0]     gnt_o,
    output logic [NCH*WIDTH-1:0] cnt_o,
    output logic [NCH-1:0]     wrap_o,
    output logic               busy_o
);

    localparam int unsigned PtrW = $clog2(NCH);
    localparam logic [WIDTH-1:0] InitV = WIDTH'(INITVAL);
    localparam logic [WIDTH-1:0] DefD  = WIDTH'(DEFDELTA);

    logic [NCH-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            wrap_q, wrap_d;
    logic [PtrW-1:0]           ptr_q, ptr_d;

    logic [PtrW-1:0]  arb_idx;
    logic             arb_vld;
    logic [WIDTH-1:0] add_op;
    logic [WIDTH:0]   add_sum;

    cnt_rr_arb #(
        .NCH  (NCH),
        .PtrW (PtrW)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt_o),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // Single shared adder: operands muxed by the winning index.
    always_comb begin
        add_op  = use_def_i[arb_idx] ? DefD : delta_i[arb_idx*WIDTH +: WIDTH];
        add_sum = {1'b0, cnt_q[arb_idx]} + {1'b0, add_op};
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = '0;
        if (arb_vld && !clr_i[arb_idx]) begin
            cnt_d[arb_idx]  = add_sum[WIDTH-1:0];
            wrap_d[arb_idx] = add_sum[WIDTH];
        end
        // Clear overrides any update, granted or not.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (clr_i[i]) begin
                cnt_d[i] = InitV;
            end
        end
        // A cleared grant still consumes its turn.
        ptr_d = PtrW'(rr_next(32'(ptr_q), 32'(arb_idx), arb_vld, NCH));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q  <= {NCH{InitV}};
            wrap_q <= '0;
            ptr_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ptr_q  <= ptr_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;
    assign busy_o = |req_i;

endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: directed self-checking bench for cnt_sched (NCH=4, WIDTH=4, INITVAL=1, DEFDELTA=10).
module tb_cnt_sched;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  use_def;
    logic [15:0] delta;
    logic [3:0]  clr;
    logic [3:0]  gnt;
    logic [15:0] cnt;
    logic [3:0]  wrap;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    cnt_sched #(
        .NCH      (4),
        .WIDTH    (4),
        .INITVAL  (1),
        .DEFDELTA (10)
    ) dut (
        .clock_i   (clock),
        .reset_i   (reset),
        .req_i     (req),
        .use_def_i (use_def),
        .delta_i   (delta),
        .clr_i     (clr),
        .gnt_o     (gnt),
        .cnt_o     (cnt),
        .wrap_o    (wrap),
        .busy_o    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        use_def = '0;
        delta   = '0;
        clr     = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_cnt", 32'(cnt), 32'h1111);
        check_eq("rst_wrap", 32'(wrap), 32'h0);
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);

        // Default delta on channel 2: 1 -> 11 -> 5 with wrap on the second.
        req     = 4'b0100;
        use_def = 4'b0100;
        #1;
        check_eq("def_gnt", 32'(gnt), 32'h4);
        check_eq("def_busy", 32'(busy), 32'h1);
        step();
        check_eq("def_cnt1", 32'(cnt), 32'h1B11);
        check_eq("def_wrap1", 32'(wrap), 32'h0);
        step();
        check_eq("def_cnt2", 32'(cnt), 32'h1511);
        check_eq("def_wrap2", 32'(wrap), 32'h4);
        req     = '0;
        use_def = '0;
        step();
        check_eq("idle_wrap", 32'(wrap), 32'h0);
        check_eq("idle_cnt", 32'(cnt), 32'h1511);

        // Pointer now 3: req 0101 must pick channel 0, then pointer is 1.
        delta = 16'h1111;
        req   = 4'b0101;
        #1;
        check_eq("ptr_gnt0", 32'(gnt), 32'h1);
        step();
        check_eq("ptr_cnt", 32'(cnt), 32'h1512);
        #1;
        check_eq("ptr_gnt2", 32'(gnt), 32'h4);

        // Clear collides with grant on channel 1.
        req   = 4'b0010;
        clr   = 4'b0010;
        delta = 16'h1131;
        #1;
        check_eq("clr_gnt", 32'(gnt), 32'h2);
        step();
        clr   = '0;
        delta = 16'h1111;
        check_eq("clr_cnt", 32'(cnt), 32'h1512);
        check_eq("clr_wrap", 32'(wrap), 32'h0);
        req = 4'b1111;
        #1;
        check_eq("clr_ptr_gnt", 32'(gnt), 32'h4);

        // Reset mid-stream with pointer at 2.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mrst_cnt", 32'(cnt), 32'h1111);
        check_eq("mrst_wrap", 32'(wrap), 32'h0);
        #1;
        check_eq("mrst_gnt", 32'(gnt), 32'h1);

        // Fairness: all requesting, deltas of 1, eight cycles.
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("fair_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            step();
            check_eq($sformatf("fair_wrap%0d", k), 32'(wrap), 32'h0);
        end
        check_eq("fair_cnt", 32'(cnt), 32'h3333);

        // Clear on a non-granted channel while channel 0 updates.
        req = 4'b0001;
        clr = 4'b0100;
        step();
        clr = '0;
        check_eq("side_clr_cnt", 32'(cnt), 32'h3134);

        // Explicit delta overflow on channel 1: 3 + 15 = 2 with carry.
        req   = 4'b0010;
        delta = 16'h11F1;
        #1;
        check_eq("ovf_gnt", 32'(gnt), 32'h2);
        step();
        req = '0;
        check_eq("ovf_cnt", 32'(cnt), 32'h3124);
        check_eq("ovf_wrap", 32'(wrap), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
